// File: rtl/bm_dag1_result_fifo.sv
// Result collector for the {out1, out0} pair: DEPTH-entry circular FIFO with a
// valid/ready drain side, dropped-write counting, and optional parity (DAG1_PARITY_EN).
module bm_dag1_result_fifo #(
    parameter int BITS  = 2,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [BITS-1:0] res0,
    input  logic            res1,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS:0]   out_data,
    output logic [AW:0]     count,
    output logic [7:0]      drop_cnt,
`ifdef DAG1_PARITY_EN
    output logic            out_par,
`endif
    output logic            overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    function automatic logic calc_par(input logic [BITS:0] data);
        return ^data;
    endfunction

    logic [BITS:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [7:0]      drop_cnt_r;
    logic            overflow_r;
    logic            push_s;
    logic            pop_s;
    logic            drop_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic [BITS:0]   wr_data_s;
    logic [BITS:0]   out_data_s;
`ifdef DAG1_PARITY_EN
    logic            par_mem_r [DEPTH];
    logic            out_par_s;
`endif

    // Handshake decode; full and empty come from the occupancy count alone.
    always_comb begin
        in_ready_s  = (count_r != FULL_CNT);
        out_valid_s = (count_r != {(AW+1){1'b0}});
        push_s      = in_valid & in_ready_s;
        pop_s       = out_valid_s & out_ready;
        drop_s      = in_valid & ~in_ready_s;
        wr_data_s   = {res1, res0};
    end

    // Storage write; contents are don't-care after reset so no reset term.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data_s;
`ifdef DAG1_PARITY_EN
            par_mem_r[wr_ptr_r] <= calc_par(wr_data_s);
`endif
        end
    end

    // Pointers, occupancy, and drop bookkeeping; reset overrides any transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            drop_cnt_r <= 8'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 8'hFF) begin
                    drop_cnt_r <= drop_cnt_r + 8'd1;
                end
            end
        end
    end

    // Head-of-queue view; forced to zero when empty, never bypassed from the input.
    always_comb begin
        if (out_valid_s) begin
            out_data_s = mem_r[rd_ptr_r];
        end else begin
            out_data_s = {(BITS+1){1'b0}};
        end
`ifdef DAG1_PARITY_EN
        if (out_valid_s) begin
            out_par_s = par_mem_r[rd_ptr_r];
        end else begin
            out_par_s = 1'b0;
        end
`endif
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign count     = count_r;
    assign drop_cnt  = drop_cnt_r;
    assign overflow  = overflow_r;
`ifdef DAG1_PARITY_EN
    assign out_par   = out_par_s;
`endif

endmodule
